sgd_gradient_mlw: RTL and testbench

Parametrised bit-serial gradient engine for the MLWeaving SGD pipeline. For each sample it latches one signed loss per bank, consumes the sample's MSB-first bit-planes from the feature FIFO with a valid/ready handshake, and masks, reduces and shift-accumulates the plane data into one fixed-point gradient per lane. It sits between the dot-product/loss stage and the model-update stage. It generalises bank count, lane count and precision, and adds input back-pressure, saturation, a chunk index and clean sample framing.

---
 rtl/sgd_gradient_mlw.sv | 238 +++++++++++++++++++++++
 tb/tb_sgd_gradient_mlw.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_gradient_mlw.sv
// Bit-serial SGD gradient engine: masks loss per bank with feature bit-planes,
// reduces across banks, shift-accumulates MSB-first and emits saturated lanes.
// Ports: clk/rst_n, started, config (number_of_bits, dimension),
//   loss_* handshake (one loss per bank), a_* handshake (bit-plane words),
//   grad_* result (valid pulse, data, chunk, last), busy.
module sgd_gradient_mlw #(
   parameter int NUM_BANKS = 8,
   parameter int LANES     = 64,
   parameter int MAX_BITS  = 32,
   parameter int GUARD     = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       started,
   input  logic [31:0]                number_of_bits,
   input  logic [31:0]                dimension,
   input  logic                       loss_valid,
   input  logic [32*NUM_BANKS-1:0]    loss_data,
   output logic                       loss_ready,
   input  logic                       a_valid,
   input  logic [LANES*NUM_BANKS-1:0] a_data,
   output logic                       a_ready,
   output logic                       grad_valid,
   output logic [32*LANES-1:0]        grad_data,
   output logic [15:0]                grad_chunk,
   output logic                       grad_last,
   output logic                       busy
);

   localparam int LB = $clog2(NUM_BANKS);
   localparam int PW = 32 + LB;
   localparam int AW = PW + GUARD;
   localparam int NN = 2 * NUM_BANKS - 1;
   localparam int NS = LB + 3;

   // Reduction tree is stored heap-style: level l starts at lvl_off(l).
   function automatic int lvl_off(input int l);
      return 2 * NUM_BANKS - ((2 * NUM_BANKS) >> l);
   endfunction

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

   typedef struct packed {
      logic        v;
      logic [5:0]  b;
      logic        fin;
      logic [15:0] chunk;
      logic        last;
   } tag_t;

   state_t              state_q, state_d;
   logic [5:0]          bit_q, bit_d;
   logic [15:0]         chunk_q, chunk_d;
   logic [5:0]          nb_q, nb_d;
   logic [15:0]         nc_q, nc_d;
   logic                gap_q, gap_d;
   logic signed [31:0]  loss_q [NUM_BANKS];
   logic signed [31:0]  loss_d [NUM_BANKS];
   tag_t                tag_q [NS];
   tag_t                tag_d [NS];
   logic signed [PW-1:0] node_q [NN][LANES];
   logic signed [PW-1:0] node_d [NN][LANES];
   logic signed [AW-1:0] sh_q [LANES];
   logic signed [AW-1:0] sh_d [LANES];
   logic signed [AW-1:0] acc_q [LANES];
   logic signed [AW-1:0] acc_d [LANES];
   logic                gv_q, gv_d;
   logic [32*LANES-1:0] gd_q, gd_d;
   logic [15:0]         gc_q, gc_d;
   logic                gl_q, gl_d;

   logic                accept;
   logic                pend;
   logic [5:0]          nb_cfg;
   logic [15:0]         nc_cfg;
   logic [32:0]         ceil_w;
   logic signed [AW-1:0] ext;
   logic signed [AW-1:0] sv;
   logic [AW-32:0]      hi;

   assign loss_ready = (state_q == IDLE) & started & ~gap_q;
   assign a_ready    = (state_q == BUSY);
   assign busy       = (state_q != IDLE);
   assign grad_valid = gv_q;
   assign grad_data  = gd_q;
   assign grad_chunk = gc_q;
   assign grad_last  = gl_q;
   assign accept     = loss_valid & loss_ready;

   always_comb begin
      nb_cfg = number_of_bits[5:0];
      if (number_of_bits == 32'd0 || number_of_bits > 32'(MAX_BITS))
         nb_cfg = 6'(MAX_BITS);
      ceil_w = ({1'b0, dimension} + 33'(LANES - 1)) / 33'(LANES);
      nc_cfg = (ceil_w > 33'd65535) ? 16'hFFFF : ceil_w[15:0];
   end

   always_comb begin
      pend = 1'b0;
      for (int s = 0; s < NS; s++)
         pend = pend | tag_q[s].v;
   end

   // Control: sample config on acceptance, step bit/chunk per consumed plane.
   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      chunk_d  = chunk_q;
      nb_d     = nb_q;
      nc_d     = nc_q;
      loss_d   = loss_q;
      gap_d    = accept;
      tag_d[0] = '0;
      for (int s = 1; s < NS; s++)
         tag_d[s] = tag_q[s-1];
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               for (int k = 0; k < NUM_BANKS; k++)
                  loss_d[k] = loss_data[32*k +: 32];
               nb_d    = nb_cfg;
               nc_d    = nc_cfg;
               bit_d   = '0;
               chunk_d = '0;
               if (nc_cfg != 16'd0)
                  state_d = BUSY;
            end
         end
         BUSY: begin
            if (a_valid) begin
               tag_d[0].v     = 1'b1;
               tag_d[0].b     = bit_q;
               tag_d[0].fin   = (bit_q == nb_q - 6'd1);
               tag_d[0].chunk = chunk_q;
               tag_d[0].last  = (bit_q == nb_q - 6'd1) &&
                                (chunk_q == nc_q - 16'd1);
               if (bit_q == nb_q - 6'd1) begin
                  bit_d = '0;
                  if (chunk_q == nc_q - 16'd1)
                     state_d = DRAIN;
                  else
                     chunk_d = chunk_q + 16'd1;
               end else begin
                  bit_d = bit_q + 6'd1;
               end
            end
         end
         DRAIN: begin
            if (!pend)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: mask, adder tree, weight shift, accumulate, saturate.
   always_comb begin
      node_d = node_q;
      sh_d   = sh_q;
      acc_d  = acc_q;
      gd_d   = gd_q;
      gc_d   = gc_q;
      ext    = '0;
      sv     = '0;
      hi     = '0;
      for (int k = 0; k < NUM_BANKS; k++)
         for (int i = 0; i < LANES; i++)
            node_d[k][i] = a_data[k*LANES+i] ?
               {{LB{loss_q[k][31]}}, loss_q[k]} : '0;
      for (int l = 1; l <= LB; l++)
         for (int j = 0; j < (NUM_BANKS >> l); j++)
            for (int i = 0; i < LANES; i++)
               node_d[lvl_off(l)+j][i] =
                  node_q[lvl_off(l-1)+2*j][i] +
                  node_q[lvl_off(l-1)+2*j+1][i];
      for (int i = 0; i < LANES; i++) begin
         ext     = AW'(node_q[NN-1][i]);
         ext     = ext <<< GUARD;
         // Plane b carries weight 2^-(b+1); arithmetic shift floors.
         sh_d[i] = ext >>> (7'(tag_q[LB].b) + 7'd1);
      end
      if (tag_q[LB+1].v)
         for (int i = 0; i < LANES; i++)
            acc_d[i] = (tag_q[LB+1].b == 6'd0) ?
               sh_q[i] : acc_q[i] + sh_q[i];
      gv_d = tag_q[LB+2].v & tag_q[LB+2].fin;
      gl_d = gv_d & tag_q[LB+2].last;
      if (gv_d) begin
         gc_d = tag_q[LB+2].chunk;
         for (int i = 0; i < LANES; i++) begin
            sv = acc_q[i] >>> GUARD;
            hi = sv[AW-1:31];
            if ((&hi) || !(|hi))
               gd_d[32*i +: 32] = sv[31:0];
            else
               gd_d[32*i +: 32] = hi[AW-32] ?
                  32'h8000_0000 : 32'h7FFF_FFFF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bit_q   <= '0;
         chunk_q <= '0;
         nb_q    <= '0;
         nc_q    <= '0;
         gap_q   <= 1'b1;
         loss_q  <= '{default: '0};
         tag_q   <= '{default: '0};
         node_q  <= '{default: '0};
         sh_q    <= '{default: '0};
         acc_q   <= '{default: '0};
         gv_q    <= 1'b0;
         gd_q    <= '0;
         gc_q    <= '0;
         gl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         chunk_q <= chunk_d;
         nb_q    <= nb_d;
         nc_q    <= nc_d;
         gap_q   <= gap_d;
         loss_q  <= loss_d;
         tag_q   <= tag_d;
         node_q  <= node_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         gv_q    <= gv_d;
         gd_q    <= gd_d;
         gc_q    <= gc_d;
         gl_q    <= gl_d;
      end
   end

endmodule

// File: tb/tb_sgd_gradient_mlw.sv
// Testbench for sgd_gradient_mlw: randomized samples checked against an
// arithmetic reference model, plus literal pins for the directed cases.
module tb_sgd_gradient_mlw;

   localparam int NUM_BANKS = 8;
   localparam int LANES     = 64;
   localparam int MAX_BITS  = 32;
   localparam int GUARD     = 4;
   localparam int LB        = $clog2(NUM_BANKS);
   localparam int LAT       = LB + 4;
   localparam int PWD       = LANES * NUM_BANKS;

   typedef logic [PWD-1:0]      plane_t;
   typedef logic [32*LANES-1:0] gvec_t;
   typedef struct {
      int          due;
      logic [15:0] chunk;
      logic        last;
      gvec_t       data;
   } exp_t;

   logic                      clk;
   logic                      rst_n;
   logic                      started;
   logic [31:0]               number_of_bits;
   logic [31:0]               dimension;
   logic                      loss_valid;
   logic [32*NUM_BANKS-1:0]   loss_data;
   logic                      loss_ready;
   logic                      a_valid;
   logic [PWD-1:0]            a_data;
   logic                      a_ready;
   logic                      grad_valid;
   logic [32*LANES-1:0]       grad_data;
   logic [15:0]               grad_chunk;
   logic                      grad_last;
   logic                      busy;

   sgd_gradient_mlw #(
      .NUM_BANKS(NUM_BANKS), .LANES(LANES),
      .MAX_BITS(MAX_BITS), .GUARD(GUARD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .started(started),
      .number_of_bits(number_of_bits), .dimension(dimension),
      .loss_valid(loss_valid), .loss_data(loss_data),
      .loss_ready(loss_ready), .a_valid(a_valid), .a_data(a_data),
      .a_ready(a_ready), .grad_valid(grad_valid),
      .grad_data(grad_data), .grad_chunk(grad_chunk),
      .grad_last(grad_last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   plane_t planes_q[$];
   logic signed [31:0] loss [NUM_BANKS];
   bit    busy_exp = 0;
   gvec_t held_d = '0;
   logic [15:0] held_c = '0;
   gvec_t cap_data = '0;
   logic [15:0] cap_chunk = '0;
   logic cap_last = 0;
   int    last_gv_edge = 0;
   int    acc_edge_g = 0;
   int    pulses = 0;

   task automatic chk(input string nm, input bit ok,
                      input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, req, $time);
      end
   endtask

   function automatic plane_t rand_plane();
      plane_t p;
      for (int w = 0; w < PWD; w += 32) p[w +: 32] = $urandom;
      return p;
   endfunction

   // Reference: per lane, sum over planes of floor(partial*2^G / 2^(b+1)),
   // then floor by 2^G and clamp to the signed 32-bit range.
   function automatic gvec_t model_chunk(input int n,
                                         input plane_t pl[MAX_BITS]);
      gvec_t g;
      for (int i = 0; i < LANES; i++) begin
         longint acc = 0;
         longint y;
         for (int b = 0; b < n; b++) begin
            longint p = 0;
            for (int k = 0; k < NUM_BANKS; k++)
               if (pl[b][k*LANES+i]) p += longint'(loss[k]);
            acc += (p * (64'sd1 << GUARD)) >>> (b + 1);
         end
         y = acc >>> GUARD;
         if (y > 64'sd2147483647) y = 64'sd2147483647;
         if (y < -64'sd2147483648) y = -64'sd2147483648;
         g[32*i +: 32] = y[31:0];
      end
      return g;
   endfunction

   // Compare process: every cycle, outputs vs the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         held_d   = '0;
         held_c   = '0;
         busy_exp = 0;
      end else begin
         if (busy_exp)
            chk("ready_low_busy", loss_ready == 0 && busy == 1,
                {loss_ready, busy}, 2'b01);
         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("grad_missing", 0, cyc, exp_q[0].due);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            int bad;
            e = exp_q.pop_front();
            chk("grad_valid", grad_valid == 1, grad_valid, 1);
            chk("grad_chunk", grad_chunk == e.chunk, grad_chunk, e.chunk);
            chk("grad_last", grad_last == e.last, grad_last, e.last);
            bad = -1;
            for (int i = LANES - 1; i >= 0; i--)
               if (grad_data[32*i +: 32] != e.data[32*i +: 32]) bad = i;
            if (bad < 0)
               chk("grad_data", 1, 0, 0);
            else
               chk($sformatf("grad_data_lane%0d", bad), 0,
                   grad_data[32*bad +: 32], e.data[32*bad +: 32]);
            held_d       = e.data;
            held_c       = e.chunk;
            cap_data     = grad_data;
            cap_chunk    = grad_chunk;
            cap_last     = grad_last;
            last_gv_edge = cyc;
            pulses++;
            if (e.last) busy_exp = 0;
         end else begin
            chk("grad_idle", grad_valid == 0 && grad_last == 0,
                {grad_valid, grad_last}, 0);
            chk("grad_hold", grad_data == held_d && grad_chunk == held_c,
                grad_chunk, held_c);
         end
      end
   end

   task automatic check_zero(input string nm);
      chk({nm, "_gv"}, grad_valid == 0, grad_valid, 0);
      chk({nm, "_gd"}, grad_data == '0 && grad_chunk == 0 && grad_last == 0,
          grad_chunk, 0);
      chk({nm, "_ctl"}, {busy, loss_ready, a_ready} == 3'b000,
          {busy, loss_ready, a_ready}, 0);
   endtask

   task automatic run_sample(input int nbits, input int dim, input int gap,
                             input int abort_at, input bit drop_started);
      int nb, nc, t, consumed;
      bit r, v;
      plane_t cp[MAX_BITS];
      nb = (nbits == 0 || nbits > MAX_BITS) ? MAX_BITS : nbits;
      nc = (dim + LANES - 1) / LANES;
      number_of_bits = nbits;
      dimension      = dim;
      for (int k = 0; k < NUM_BANKS; k++) loss_data[32*k +: 32] = loss[k];
      loss_valid = 1;
      t = 0;
      do begin
         #1 r = loss_ready;
         @(posedge clk); #1;
         t++;
      end while (!r && t < 300);
      loss_valid = 0;
      if (!r) begin
         chk("loss_accept_timeout", 0, t, 300);
         return;
      end
      acc_edge_g = cyc;
      if (nc == 0) begin
         chk("nc0_gap", loss_ready == 0 && busy == 0,
             {loss_ready, busy}, 0);
         @(posedge clk); #1;
         chk("nc0_back", loss_ready == 1 && busy == 0,
             {loss_ready, busy}, 2'b10);
         return;
      end
      busy_exp = 1;
      if (drop_started) started = 0;
      consumed = 0;
      for (int c = 0; c < nc; c++) begin
         for (int b = 0; b < nb; b++) begin
            plane_t p;
            p = (planes_q.size() > 0) ? planes_q.pop_front() : rand_plane();
            cp[b] = p;
            t = 0;
            do begin
               v = ($urandom_range(99) >= gap);
               a_valid = v;
               a_data  = v ? p : rand_plane();
               #1 r = a_ready;
               if (v) chk("a_ready", r == 1, r, 1);
               @(posedge clk); #1;
               t++;
            end while (!(v && r) && t < 1000);
            if (!(v && r)) begin
               chk("plane_timeout", 0, t, 1000);
               a_valid = 0;
               return;
            end
            if (b == nb - 1) begin
               exp_t e;
               e.due   = cyc + LAT - 1;
               e.chunk = 16'(c);
               e.last  = (c == nc - 1);
               e.data  = model_chunk(nb, cp);
               exp_q.push_back(e);
            end
            consumed++;
            if (consumed == abort_at) begin
               a_valid = 0;
               rst_n = 0;
               #1;
               check_zero("abort");
               busy_exp = 0;
               @(posedge clk); #1;
               rst_n = 1;
               return;
            end
         end
      end
      a_valid = 0;
      chk("a_ready_drop", a_ready == 0 && busy == 1, {a_ready, busy}, 1);
      t = 0;
      while (busy_exp && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      if (busy_exp) begin
         chk("drain_timeout", 0, t, 300);
         busy_exp = 0;
      end
      chk("idle_after_last", busy == 0 && loss_ready == started,
          {busy, loss_ready}, {1'b0, started});
      started = 1;
   endtask

   task automatic set_loss_all(input logic [31:0] v);
      for (int k = 0; k < NUM_BANKS; k++) loss[k] = v;
   endtask

   initial begin
      plane_t p1;
      int bad;
      rst_n = 1; started = 1; number_of_bits = 0; dimension = 0;
      loss_valid = 0; loss_data = '0; a_valid = 0; a_data = '0;
      #2 rst_n = 0;
      #1 check_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // NB=1, all ones, loss 256 everywhere -> 1024 per lane.
      set_loss_all(32'd256);
      planes_q.push_back('1);
      run_sample(1, 64, 0, -1, 0);
      bad = 0;
      for (int i = 0; i < LANES; i++)
         if (cap_data[32*i +: 32] != 32'd1024) bad++;
      chk("t1_lanes_1024", bad == 0, bad, 0);
      chk("t1_chunk_last", cap_chunk == 0 && cap_last == 1,
          {cap_chunk, cap_last}, 1);
      chk("t1_latency", (last_gv_edge - acc_edge_g) + 1 == LAT + 1,
          last_gv_edge - acc_edge_g + 1, LAT + 1);

      // NB=4, bank 0 loss 160, lane 0 bits 1111 -> 150.
      set_loss_all(32'd0);
      loss[0] = 32'sd160;
      p1 = '0;
      p1[0] = 1'b1;
      repeat (4) planes_q.push_back(p1);
      run_sample(4, 64, 0, -1, 0);
      chk("t2_lane0", cap_data[31:0] == 32'd150, cap_data[31:0], 150);
      chk("t2_lane1", cap_data[63:32] == 32'd0, cap_data[63:32], 0);

      // Floor behaviour of negative losses.
      set_loss_all(32'd0);
      loss[3] = -32'sd1;
      planes_q.push_back('1);
      run_sample(1, 64, 0, -1, 0);
      chk("t3_neg1", cap_data[32*5 +: 32] == 32'hFFFF_FFFF,
          cap_data[32*5 +: 32], 32'hFFFF_FFFF);
      loss[3] = -32'sd3;
      planes_q.push_back('1);
      planes_q.push_back('0);
      run_sample(2, 64, 0, -1, 0);
      chk("t3_neg3", cap_data[32*9 +: 32] == 32'hFFFF_FFFE,
          cap_data[32*9 +: 32], 32'hFFFF_FFFE);

      // Saturation at both ends.
      set_loss_all(32'h7FFF_FFFF);
      planes_q.push_back('1);
      run_sample(1, 64, 0, -1, 0);
      chk("sat_pos", cap_data[31:0] == 32'h7FFF_FFFF,
          cap_data[31:0], 32'h7FFF_FFFF);
      set_loss_all(32'h8000_0000);
      planes_q.push_back('1);
      run_sample(1, 64, 0, -1, 0);
      chk("sat_neg", cap_data[32*63 +: 32] == 32'h8000_0000,
          cap_data[32*63 +: 32], 32'h8000_0000);

      // dimension=130: three chunks with gaps, started dropped mid-sample.
      for (int k = 0; k < NUM_BANKS; k++) loss[k] = $urandom;
      pulses = 0;
      run_sample(3, 130, 40, -1, 1);
      chk("t5_pulses", pulses == 3, pulses, 3);
      chk("t5_final", cap_chunk == 2 && cap_last == 1,
          {cap_chunk, cap_last}, {16'd2, 1'b1});

      // dimension=0: accepted, no output.
      pulses = 0;
      run_sample(5, 0, 0, -1, 0);
      repeat (LAT + 2) @(posedge clk);
      #1 chk("nc0_no_pulse", pulses == 0, pulses, 0);

      // number_of_bits 0 and over-range clamp to MAX_BITS.
      for (int k = 0; k < NUM_BANKS; k++) loss[k] = $urandom;
      pulses = 0;
      run_sample(0, 64, 10, -1, 0);
      run_sample(40, 10, 10, -1, 0);
      chk("clamp_pulses", pulses == 2, pulses, 2);

      // Reset mid-BUSY, then a clean sample.
      for (int k = 0; k < NUM_BANKS; k++) loss[k] = $urandom;
      run_sample(3, 130, 20, 4, 0);
      for (int k = 0; k < NUM_BANKS; k++) loss[k] = $urandom;
      pulses = 0;
      run_sample(3, 70, 20, -1, 0);
      chk("post_reset_pulses", pulses == 2, pulses, 2);

      // Randomized samples.
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < NUM_BANKS; k++)
            loss[k] = ($urandom_range(1) == 1) ? $urandom :
                      32'($urandom_range(2000)) - 32'd1000;
         run_sample($urandom_range(33), $urandom_range(200),
                    $urandom_range(50), -1, 0);
      end

      repeat (LAT + 2) @(posedge clk);
      #1 chk("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
